// File: rtl/im_boot_loader_pkg.sv
// -----------------------------------------------------------------------------
// im_boot_loader_pkg
// Shared constants for the instruction-memory boot loader: FSM state
// encodings, IM geometry (1024 x 32-bit words = 4 KB) and the default
// inter-byte timeout.
// -----------------------------------------------------------------------------
package im_boot_loader_pkg;

    localparam int IM_AW           = 10;
    localparam int IM_DEPTH        = 1 << IM_AW;
    localparam int IM_BYTES        = IM_DEPTH * 4;
    localparam int TIMEOUT_DEFAULT = 1000000;

    // Header count is 16 bits; one extra bit keeps the clamp value 2^AW
    // representable and lets the word counter reach it without wrapping.
    localparam int CNT_W = 17;

    typedef logic [2:0] state_t;

    localparam state_t S_HDR_HI = 3'd0;
    localparam state_t S_HDR_LO = 3'd1;
    localparam state_t S_DATA   = 3'd2;
    localparam state_t S_DRAIN  = 3'd3;
    localparam state_t S_RUN    = 3'd4;

endpackage

// File: rtl/im_word_packer.sv
// -----------------------------------------------------------------------------
// im_word_packer
// Assembles a big-endian byte stream into 32-bit words.
//   clk, rst       clock, async active-high reset
//   flush_i        drop any partial word (byte index and shift register)
//   push_i         accept byte_i this cycle
//   byte_i         incoming byte, MSB of the word first
//   last_byte_o    comb: this push completes a word
//   word_valid_o   one-cycle pulse, registered, the cycle after the 4th byte
//   word_o         registered word, held until the next word completes
// -----------------------------------------------------------------------------
module im_word_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush_i,
    input  logic        push_i,
    input  logic [7:0]  byte_i,
    output logic        last_byte_o,
    output logic        word_valid_o,
    output logic [31:0] word_o
);

    logic [1:0]  idx_q,   idx_d;
    logic [23:0] shift_q, shift_d;
    logic [31:0] word_q,  word_d;
    logic        vld_q,   vld_d;

    assign last_byte_o = push_i & (idx_q == 2'd3);

    always_comb begin
        idx_d   = idx_q;
        shift_d = shift_q;
        word_d  = word_q;
        vld_d   = 1'b0;
        if (flush_i) begin
            idx_d   = '0;
            shift_d = '0;
        end else if (push_i) begin
            idx_d   = idx_q + 2'd1;
            shift_d = {shift_q[15:0], byte_i};
            if (idx_q == 2'd3) begin
                vld_d  = 1'b1;
                word_d = {shift_q, byte_i};
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q   <= '0;
            shift_q <= '0;
            word_q  <= '0;
            vld_q   <= 1'b0;
        end else begin
            idx_q   <= idx_d;
            shift_q <= shift_d;
            word_q  <= word_d;
            vld_q   <= vld_d;
        end
    end

    assign word_valid_o = vld_q;
    assign word_o       = word_q;

endmodule

// File: rtl/im_boot_loader.sv
// -----------------------------------------------------------------------------
// im_boot_loader
// Shares the single IM address port between a byte-stream program loader and
// the IF-stage fetch. A load is a 16-bit big-endian word count followed by
// that many big-endian 32-bit words, written to consecutive IM addresses
// from 0 while the CPU is held.
//   clk, rst       clock, async active-high reset
//   load_req_i     reload pulse, honoured only in RUN
//   byte_valid_i   loader byte valid
//   byte_data_i    loader byte
//   byte_ready_o   byte accepted when byte_valid_i && byte_ready_o
//   pc_addr_i      fetch word address
//   im_addr_o      IM address: pc_addr_i in RUN, else write pointer (comb)
//   im_we_o        IM write strobe (one cycle)
//   im_wdata_o     IM write data
//   cpu_hold_o     pipeline stall, high in every state but RUN
//   load_err_o     sticky error (oversized header or timeout)
// -----------------------------------------------------------------------------
module im_boot_loader
    import im_boot_loader_pkg::*;
#(
    parameter int AW            = IM_AW,
    parameter int BOOT_ON_RESET = 1,
    parameter int TIMEOUT       = TIMEOUT_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_req_i,
    input  logic          byte_valid_i,
    input  logic [7:0]    byte_data_i,
    output logic          byte_ready_o,
    input  logic [AW-1:0] pc_addr_i,
    output logic [AW-1:0] im_addr_o,
    output logic          im_we_o,
    output logic [31:0]   im_wdata_o,
    output logic          cpu_hold_o,
    output logic          load_err_o
);

    localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(1 << AW);
    localparam logic [31:0]      TO_LAST   = 32'(TIMEOUT - 1);
    localparam bit               TO_EN     = (TIMEOUT != 0);
    localparam bit               BOOT      = (BOOT_ON_RESET != 0);
    localparam state_t           RST_STATE = BOOT ? S_HDR_HI : S_RUN;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] wcnt_q,  wcnt_d;
    logic [CNT_W-1:0] hdr_cnt;
    logic [AW-1:0]    wptr_q,  wptr_d;
    logic [31:0]      tcnt_q,  tcnt_d;
    logic             err_q,   err_d;
    logic             hold_q,  hold_d;
    logic             rdy_q,   rdy_d;

    logic        accept, push, start, timeout, flush;
    logic        last_byte, word_valid;
    logic [31:0] word;

    assign accept  = byte_valid_i & rdy_q;
    assign push    = accept & (state_q == S_DATA);
    assign start   = load_req_i & (state_q == S_RUN);
    // Fires on the TIMEOUT-th consecutive cycle without an accepted byte.
    assign timeout = TO_EN & rdy_q & ~accept & (tcnt_q == TO_LAST);
    assign flush   = start | timeout;
    assign hdr_cnt = {1'b0, count_q[15:8], byte_data_i};

    im_word_packer u_packer (
        .clk          (clk),
        .rst          (rst),
        .flush_i      (flush),
        .push_i       (push),
        .byte_i       (byte_data_i),
        .last_byte_o  (last_byte),
        .word_valid_o (word_valid),
        .word_o       (word)
    );

    // ---------------- state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= RST_STATE;
        else     state_q <= state_d;
    end

    // ---------------- next state + load bookkeeping ----------------
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        wcnt_d  = wcnt_q;
        err_d   = err_q;
        unique case (state_q)
            S_HDR_HI: if (accept) begin
                count_d = {1'b0, byte_data_i, 8'h00};
                state_d = S_HDR_LO;
            end
            S_HDR_LO: if (accept) begin
                if (hdr_cnt == '0) begin
                    state_d = S_DRAIN;
                end else if (hdr_cnt > DEPTH_C) begin
                    err_d   = 1'b1;
                    count_d = DEPTH_C;
                    state_d = S_DATA;
                end else begin
                    count_d = hdr_cnt;
                    state_d = S_DATA;
                end
            end
            // Leave DATA on the last byte so DRAIN coincides with the
            // final im_we pulse.
            S_DATA: if (last_byte) begin
                wcnt_d = wcnt_q + 1'b1;
                if (wcnt_d == count_q) state_d = S_DRAIN;
            end
            S_DRAIN: state_d = S_RUN;
            S_RUN: if (load_req_i) begin
                state_d = S_HDR_HI;
                err_d   = 1'b0;
                wcnt_d  = '0;
                count_d = '0;
            end
            default: state_d = RST_STATE;
        endcase
        if (timeout) begin
            err_d   = 1'b1;
            state_d = S_DRAIN;
        end
    end

    // Pointer saturates at the last word; the clamp guarantees no more than
    // 2^AW writes, so saturation only keeps it from wrapping to 0 afterwards.
    always_comb begin
        wptr_d = wptr_q;
        if (start)                          wptr_d = '0;
        else if (word_valid && ~&wptr_q)    wptr_d = wptr_q + 1'b1;
        tcnt_d = (rdy_q && !accept && !timeout) ? tcnt_q + 32'd1 : '0;
    end

    // ---------------- output decode ----------------
    always_comb begin
        rdy_d  = (state_d == S_HDR_HI) || (state_d == S_HDR_LO) || (state_d == S_DATA);
        hold_d = (state_d != S_RUN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
            wcnt_q  <= '0;
            wptr_q  <= '0;
            tcnt_q  <= '0;
            err_q   <= 1'b0;
            hold_q  <= BOOT;
            rdy_q   <= BOOT;
        end else begin
            count_q <= count_d;
            wcnt_q  <= wcnt_d;
            wptr_q  <= wptr_d;
            tcnt_q  <= tcnt_d;
            err_q   <= err_d;
            hold_q  <= hold_d;
            rdy_q   <= rdy_d;
        end
    end

    assign im_addr_o    = (state_q == S_RUN) ? pc_addr_i : wptr_q;
    assign im_we_o      = word_valid;
    assign im_wdata_o   = word;
    assign byte_ready_o = rdy_q;
    assign cpu_hold_o   = hold_q;
    assign load_err_o   = err_q;

endmodule
